ibus_mem_responder: RTL and testbench
=====================================

Name: ibus_mem_responder

Overview:
Instruction-bus responder: the slave end of the ibus_req_t/ibus_resp_t handshake issued by the fetch stage. It accepts one fetch request at a time and returns a 32-bit instruction word after a fixed, parameterised latency. Words come from an internal word-addressed instruction memory that is loaded through a preload write port. It sits between the fetch stage and memory in simulation and bring-up builds, and models multi-cycle instruction latency for stall testing.

Parameters:
LATENCY, 2, cycles from acceptance (addr_ok cycle) to data_ok cycle; legal range 1..15
DEPTH_WORDS, 1024, number of 32-bit words in the instruction memory; power of two
BASE_ADDR, 64'h8000_0000, byte address mapped to word 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
ireq  in  ibus_req_t  fetch request: valid, addr[63:0]
iresp  out  ibus_resp_t  addr_ok, data_ok, data[31:0]
fault  out  1  qualifies data_ok: request was misaligned or out of range
init_we  in  1  preload write enable
init_idx  in  $clog2(DEPTH_WORDS)  preload word index
init_data  in  32  preload word

Behaviour:
- States: IDLE, WAIT, RESP; plus a 4-bit down-counter cnt and a 64-bit latched addr_q.
- Reset (reset==0 at a clock edge):
  - state=IDLE, cnt=0, addr_q=0;
  - registered iresp.data=0, fault=0;
  - iresp.addr_ok=0, iresp.data_ok=0;
  - memory contents are NOT cleared.
  - A transaction in flight is dropped: no data_ok is produced.
- IDLE:
  - iresp.addr_ok = ireq.valid (combinational, this cycle only).
  - If ireq.valid: addr_q<=ireq.addr, cnt<=LATENCY-1; next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - addr_ok=0, data_ok=0.
  - cnt decrements each cycle; when cnt==1, next state is RESP.
  - On the edge entering RESP, data and fault are registered from addr_q.
- RESP:
  - iresp.data_ok=1 for exactly one cycle; data and fault hold their registered values.
  - Next state is IDLE. A new request is accepted no earlier than the following cycle.
- Timing and throughput:
  - Acceptance at cycle t gives data_ok at cycle t+LATENCY.
  - Peak throughput is one request per LATENCY+1 cycles.
- Once accepted, a request always completes, even if ireq.valid drops or ireq.addr changes (e.g. branch redirect). The fetch side discards stale data.
- Addressing:
  - off = addr_q - BASE_ADDR (64-bit unsigned, wraps);
  - idx = off[63:2];
  - in_range = (addr_q >= BASE_ADDR) && (idx < DEPTH_WORDS).
- fault=1 when addr_q[1:0]!=0 or !in_range; in that case data=32'h0. Otherwise data=mem[idx].
- Preload:
  - init_we writes mem[init_idx]<=init_data on the edge, in any state, including during reset.
  - Write and response-read on the same edge to the same index: the read returns the OLD word.
- iresp.data and fault outside the RESP cycle hold the last registered values; they are don't-care to consumers.

Decomposition:
- Shared package common: ibus_req_t/ibus_resp_t (already present), plus a new enum ibus_rsp_state_t {IDLE, WAIT, RESP} and constant IMEM_BASE = 64'h8000_0000.
- Sub-module imem_array (params DEPTH_WORDS):
  - one synchronous write port;
  - one synchronous read port with read-old-on-collision semantics;
  - read enable is asserted on the edge entering RESP.
- The responder FSM, counter and range/alignment checks stay in ibus_mem_responder.

Test Plan:
- Reset: hold reset=0 for 3 cycles with ireq.valid=1 -> addr_ok=0, data_ok=0, data=0, fault=0; after release, addr_ok=1 in the first cycle.
- Basic read, LATENCY=2: preload mem[4]=32'h0010_0093; request addr 64'h8000_0010 at cycle t -> addr_ok@t, data_ok@t+2, data=32'h0010_0093, fault=0; data_ok low at t+1 and t+3.
- Latency/throughput, LATENCY=1 then 3: hold ireq.valid=1 continuously on consecutive addresses -> data_ok every 2 (resp. 4) cycles; addr_ok never asserted in WAIT or RESP.
- Faults:
  - addr 64'h8000_0002 -> data_ok with fault=1, data=0;
  - addr 64'h7FFF_FFFC -> fault=1;
  - addr BASE_ADDR+4*DEPTH_WORDS -> fault=1.
- Redirect: accept 64'h8000_0000, then change ireq.addr to 64'h8000_0100 in the next cycle -> first data_ok returns mem[0]; the new address is accepted the cycle after data_ok.
- Collisions:
  - init_we to idx 0 with 32'hDEAD_BEEF on the same edge as entering RESP for addr 64'h8000_0000 -> old word returned; the next read returns 32'hDEAD_BEEF.
  - Reset asserted in WAIT -> no data_ok follows.

Source files
------------

// File: rtl/ibus_mem_responder_pkg.sv
// Shared instruction-bus types, responder FSM states and the default memory base address.
package ibus_mem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ibus_rsp_state_t;

  localparam logic [63:0] IMEM_BASE = 64'h8000_0000;

endpackage

// File: rtl/ibus_mem_responder_imem.sv
// Word-addressed instruction memory: one sync write port, one sync read port returning the old word on collision.
// Read data resets to zero; the array itself is never cleared so preloads survive reset.
module imem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Separate process so a same-edge write is not visible to this read.
  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/ibus_mem_responder.sv
// Fetch-bus slave: one request at a time, data_ok LATENCY cycles after addr_ok, one request per LATENCY+1 cycles.
// No backpressure on data_ok; addr_ok is only offered while idle, and accepted requests always complete.
module ibus_mem_responder
  import ibus_mem_responder_pkg::*;
#(
  parameter  int          LATENCY     = 2,
  parameter  int          DEPTH_WORDS = 1024,
  parameter  logic [63:0] BASE_ADDR   = IMEM_BASE,
  localparam int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  ibus_req_t     ireq,
  output ibus_resp_t    iresp,
  output logic          fault,
  input  logic          init_we,
  input  logic [AW-1:0] init_idx,
  input  logic [31:0]   init_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  ibus_rsp_state_t state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [63:0]     addr_q, addr_nx;
  logic [63:0]     chk_addr, word_off;
  logic            chk_fault, fault_q, rd_en;
  logic [31:0]     rd_data;

  // With LATENCY==1 the read is launched in the accept cycle, before addr_q holds the address.
  assign chk_addr  = (state == IDLE) ? ireq.addr : addr_q;
  assign word_off  = (chk_addr - BASE_ADDR) >> 2;
  assign chk_fault = (chk_addr[1:0] != 2'b00) || (chk_addr < BASE_ADDR) ||
                     (word_off >= 64'(DEPTH_WORDS));
  assign rd_en     = reset && (state_nx == RESP) && (state != RESP);
  assign fault     = fault_q;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    addr_nx       = addr_q;
    iresp.addr_ok = 1'b0;
    iresp.data_ok = 1'b0;
    iresp.data    = fault_q ? 32'h0 : rd_data;
    case (state)
      IDLE: begin
        iresp.addr_ok = ireq.valid;
        if (ireq.valid) begin
          addr_nx  = ireq.addr;
          cnt_nx   = CNT_INIT;
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        iresp.data_ok = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!reset) begin
      iresp.addr_ok = 1'b0;
      iresp.data_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 64'h0;
      fault_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      if (rd_en) fault_q <= chk_fault;
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_imem (
    .clk  (clk),
    .reset(reset),
    .we   (init_we),
    .widx (init_idx),
    .wdata(init_data),
    .re   (rd_en),
    .ridx (word_off[AW-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Three responders (LATENCY 1, 2, 3) share one stimulus stream; a transaction-level model predicts each one's responses.
module tb_ibus_mem_responder;
  import ibus_mem_responder_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          NI    = 3;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  logic        init_we;
  logic [9:0]  init_idx;
  logic [31:0] init_data;
  ibus_resp_t  iresp [NI];
  logic        fault [NI];

  int          cyc = 0;
  int          vec = 0;
  int          errs = 0;
  exp_t        sbq [NI][$];
  logic        exp_aok [NI];
  logic        zero_chk = 1'b0;
  logic        prev_in_rst = 1'b0;
  int          free_at [NI];
  logic        pvld [NI];
  int          presp [NI];
  logic [63:0] paddr [NI];
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibus_mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp[0]), .fault(fault[0]),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data));
  ibus_mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp[1]), .fault(fault[1]),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data));
  ibus_mem_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp[2]), .fault(fault[2]),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data));

  function automatic exp_t predict(input logic [63:0] a, input int rc);
    exp_t e;
    e.cyc   = rc;
    e.fault = 1'b1;
    e.data  = 32'h0;
    if (a >= BASE && a < BASE + 64'(4 * DEPTH) && (a % 4) == 0) begin
      e.fault = 1'b0;
      e.data  = mem_m[int'((a - BASE) / 4)];
    end
    return e;
  endfunction

  // One clock cycle of stimulus; the model reacts to what this cycle presents.
  task automatic step(input logic rst_n, input logic v, input logic [63:0] a,
                      input logic we, input int wi, input logic [31:0] wd);
    reset      = rst_n;
    ireq.valid = v;
    ireq.addr  = a;
    init_we    = we;
    init_idx   = wi[9:0];
    init_data  = wd;
    zero_chk   = !rst_n && prev_in_rst;
    for (int k = 0; k < NI; k++) begin
      exp_aok[k] = 1'b0;
      if (!rst_n) begin
        sbq[k].delete();
        pvld[k]    = 1'b0;
        free_at[k] = cyc + 1;
      end else begin
        if (v && cyc >= free_at[k]) begin
          exp_aok[k] = 1'b1;
          pvld[k]    = 1'b1;
          paddr[k]   = a;
          presp[k]   = cyc + k + 1;
          free_at[k] = cyc + k + 2;
        end
        // Memory is sampled at the end of the cycle before data_ok, ahead of this cycle's write.
        if (pvld[k] && presp[k] == cyc + 1) begin
          sbq[k].push_back(predict(paddr[k], presp[k]));
          pvld[k] = 1'b0;
        end
      end
    end
    if (we) mem_m[wi] = wd;
    prev_in_rst = !rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 0, 32'h0);
  endtask

  function automatic logic [63:0] rand_addr(input logic [63:0] prev);
    int r;
    r = $urandom_range(99);
    if (r < 40) return prev + 64'd4;
    if (r < 65) return BASE + 64'($urandom_range(DEPTH - 1)) * 4;
    if (r < 75) return BASE + 64'($urandom_range(4 * DEPTH - 1));
    if (r < 82) return BASE - 64'($urandom_range(64, 1));
    if (r < 90) return BASE + 64'(4 * DEPTH) + 64'($urandom_range(64));
    if (r < 95) return {$urandom, $urandom};
    return BASE + 64'(4 * DEPTH - 4);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      vec++;
      if (iresp[k].addr_ok !== exp_aok[k]) begin
        errs++;
        $display("FAIL lat%0d addr_ok cyc=%0d got=%b want=%b", k + 1, cyc, iresp[k].addr_ok, exp_aok[k]);
      end
      vec++;
      if (sbq[k].size() > 0 && sbq[k][0].cyc == cyc) begin
        e = sbq[k].pop_front();
        if (iresp[k].data_ok !== 1'b1) begin
          errs++;
          $display("FAIL lat%0d missing data_ok cyc=%0d got=%b want=1", k + 1, cyc, iresp[k].data_ok);
        end else if (iresp[k].data !== e.data || fault[k] !== e.fault) begin
          errs++;
          $display("FAIL lat%0d resp cyc=%0d got data=%h fault=%b want data=%h fault=%b",
                   k + 1, cyc, iresp[k].data, fault[k], e.data, e.fault);
        end
      end else if (iresp[k].data_ok !== 1'b0) begin
        errs++;
        $display("FAIL lat%0d unexpected data_ok cyc=%0d got=%b want=0", k + 1, cyc, iresp[k].data_ok);
      end
      if (zero_chk) begin
        vec++;
        if (iresp[k].data !== 32'h0 || fault[k] !== 1'b0) begin
          errs++;
          $display("FAIL lat%0d reset outputs cyc=%0d got data=%h fault=%b want 0/0",
                   k + 1, cyc, iresp[k].data, fault[k]);
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [31:0] wd;
    for (int k = 0; k < NI; k++) begin
      free_at[k] = 0;
      pvld[k]    = 1'b0;
      presp[k]   = 0;
      paddr[k]   = 64'h0;
      exp_aok[k] = 1'b0;
    end

    // Preload the whole array while held in reset with a request pending.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, BASE, 1'b1, i, (i == 4) ? 32'h0010_0093 : $urandom);

    // First cycle out of reset accepts the basic read of word 4.
    step(1'b1, 1'b1, BASE + 64'h10, 1'b0, 0, 32'h0);
    idle(5);

    foreach (mem_m[i]) if (i < 1) a = 64'h0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: a = BASE + 64'h2;
        1: a = 64'h7FFF_FFFC;
        2: a = BASE + 64'(4 * DEPTH);
        3: a = BASE + 64'(4 * DEPTH - 4);
        default: a = 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      step(1'b1, 1'b1, a, 1'b0, 0, 32'h0);
      idle(4);
    end

    // Redirect right after acceptance: first request still completes.
    step(1'b1, 1'b1, BASE, 1'b0, 0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, BASE + 64'h100, 1'b0, 0, 32'h0);
    idle(5);

    // Write to word 0 on the edge where each latency's read is launched.
    for (int k = 0; k < NI; k++) begin
      wd = (k == 1) ? 32'hDEAD_BEEF : $urandom;
      for (int j = 0; j <= k; j++) step(1'b1, j == 0, BASE, j == k, 0, wd);
      idle(4);
      step(1'b1, 1'b1, BASE, 1'b0, 0, 32'h0);
      idle(4);
    end

    // Reset while waiting drops the transaction.
    step(1'b1, 1'b1, BASE + 64'h8, 1'b0, 0, 32'h0);
    step(1'b0, 1'b0, 64'h0, 1'b0, 0, 32'h0);
    idle(5);

    a = BASE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 60) a = rand_addr(a);
      step($urandom_range(99) != 0, $urandom_range(99) < 75, a,
           $urandom_range(99) < 25,
           ($urandom_range(1) == 1) ? int'($urandom_range(7)) : int'($urandom_range(DEPTH - 1)),
           $urandom);
    end
    idle(10);

    for (int k = 0; k < NI; k++) begin
      vec++;
      if (sbq[k].size() != 0) begin
        errs++;
        $display("FAIL lat%0d drain got=%0d pending want=0", k + 1, sbq[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
